// File: rtl/vga_fb_arbiter_if.sv
// Signal bundle between the framebuffer arbiter, its display/host/clear clients and the pixel RAM.
interface vga_fb_arbiter_if #(
    parameter int PIX_W  = 3,
    parameter int ADDR_W = 15
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [PIX_W-1:0]  disp_pix;
    logic              disp_pix_vld;

    logic              host_valid;
    logic [ADDR_W-1:0] host_addr;
    logic [PIX_W-1:0]  host_data;
    logic              host_ready;

    logic              clr_start;
    logic [PIX_W-1:0]  clr_color;
    logic              clr_busy;
    logic              clr_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;

    modport slave (
        input  disp_req, disp_addr, host_valid, host_addr, host_data,
               clr_start, clr_color, mem_rdata,
        output disp_pix, disp_pix_vld, host_ready, clr_busy, clr_done,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output disp_req, disp_addr, host_valid, host_addr, host_data,
               clr_start, clr_color, mem_rdata,
        input  disp_pix, disp_pix_vld, host_ready, clr_busy, clr_done,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM arbiter: one RAM slot per cycle shared by scan-out
// reads, full-frame clear writes and a small host write buffer (in that priority).
module vga_fb_arbiter #(
    parameter int PIX_W      = 3,
    parameter int ADDR_W     = 15,
    parameter int FB_DEPTH   = 19200,
    parameter int WBUF_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    vga_fb_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;

    state_e            state_q, state_d;
    logic [PIX_W-1:0]  color_q, color_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              clr_done_q, clr_done_d;

    logic [ADDR_W-1:0] wbuf_addr_q [WBUF_DEPTH];
    logic [PIX_W-1:0]  wbuf_data_q [WBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;

    logic              rd1_q, rd2_q, pix_vld_q;
    logic [PIX_W-1:0]  pix_q;

    logic host_ready, push, pop, rd_grant, clr_grant, head_in_range;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign host_ready    = (count_q < CNT_W'(WBUF_DEPTH)) && (state_q == IDLE);
    assign push          = bus.host_valid && host_ready;
    assign head_in_range = 32'(wbuf_addr_q[rd_ptr_q]) < FB_DEPTH;

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        color_d     = color_q;
        clr_cnt_d   = clr_cnt_q;
        clr_done_d  = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_grant    = 1'b0;
        clr_grant   = 1'b0;
        pop         = 1'b0;

        if (bus.disp_req) begin
            rd_grant   = 1'b1;
            mem_en_d   = 1'b1;
            mem_addr_d = bus.disp_addr;
        end else if (state_q == CLEAR) begin
            clr_grant   = 1'b1;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = clr_cnt_q;
            mem_wdata_d = color_q;
        end else if (count_q != '0) begin
            // Out-of-range entries are popped without touching the RAM.
            pop = 1'b1;
            if (head_in_range) begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = wbuf_addr_q[rd_ptr_q];
                mem_wdata_d = wbuf_data_q[rd_ptr_q];
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.clr_start) begin
                    color_d = bus.clr_color;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    clr_cnt_d = '0;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_grant) begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == ADDR_W'(FB_DEPTH - 1)) begin
                        clr_cnt_d  = '0;
                        clr_done_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            color_q     <= '0;
            clr_cnt_q   <= '0;
            clr_done_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd1_q       <= 1'b0;
            rd2_q       <= 1'b0;
            pix_vld_q   <= 1'b0;
            pix_q       <= '0;
        end else begin
            state_q     <= state_d;
            color_q     <= color_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_done_q  <= clr_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            // Read granted -> RAM access -> RAM data -> registered pixel.
            rd1_q       <= rd_grant;
            rd2_q       <= rd1_q;
            pix_vld_q   <= rd2_q;
            if (rd2_q) begin
                pix_q <= bus.mem_rdata;
            end
        end
    end

    // NOTE: buffer storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            wbuf_addr_q[wr_ptr_q] <= bus.host_addr;
            wbuf_data_q[wr_ptr_q] <= bus.host_data;
        end
    end

    assign bus.host_ready   = host_ready;
    assign bus.clr_busy     = (state_q != IDLE);
    assign bus.clr_done     = clr_done_q;
    assign bus.mem_en       = mem_en_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.disp_pix     = pix_q;
    assign bus.disp_pix_vld = pix_vld_q;
endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter PIX_W, default 3, pixel width (R,G,B bits).
REQ-002 SHALL have parameter ADDR_W, default 15, framebuffer address width.
REQ-003 SHALL have parameter FB_DEPTH, default 19200, number of valid pixel addresses (160x120).
REQ-004 SHALL have parameter WBUF_DEPTH, default 4, host write buffer entries.
REQ-005 SHALL have port clk  input  1  single clock (40 MHz nominal); all logic rising-edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port disp_req  input  1  scan-out read request.
REQ-008 SHALL have port disp_addr  input  ADDR_W  scan-out read address.
REQ-009 SHALL have port disp_pix  output  PIX_W  returned pixel.
REQ-010 SHALL have port disp_pix_vld  output  1  disp_pix valid strobe.
REQ-011 SHALL have port host_valid  input  1  host write offer.
REQ-012 SHALL have port host_addr  input  ADDR_W  host write address.
REQ-013 SHALL have port host_data  input  PIX_W  host write pixel.
REQ-014 SHALL have port host_ready  output  1  host write accept.
REQ-015 SHALL have port clr_start  input  1  start full-frame clear.
REQ-016 SHALL have port clr_color  input  PIX_W  clear colour, sampled on clr_start.
REQ-017 SHALL have port clr_busy  output  1  clear in progress.
REQ-018 SHALL have port clr_done  output  1  one-cycle clear completion pulse.
REQ-019 SHALL have ports mem_en, mem_we (output 1), mem_addr (output ADDR_W), mem_wdata (output PIX_W), mem_rdata (input PIX_W) to a single-port synchronous RAM with 1-cycle read latency.

Function
REQ-020 SHALL register all mem_* outputs; a slot granted in cycle T drives the RAM in cycle T+1.
REQ-021 SHALL arbitrate one RAM slot per cycle, fixed priority: disp_req > clear write > write-buffer drain.
REQ-022 SHALL always grant disp_req; disp_pix_vld SHALL assert exactly 3 cycles after disp_req, with disp_pix = RAM contents at disp_addr, back-to-back requests every cycle supported.
REQ-023 SHALL pass disp_addr to RAM unchanged, including addresses >= FB_DEPTH.
REQ-024 SHALL buffer host writes in a WBUF_DEPTH-entry FIFO; a write is accepted when host_valid && host_ready.
REQ-025 SHALL drive host_ready = (buffer count < WBUF_DEPTH) && state == IDLE, combinational from registered state.
REQ-026 SHALL drain the oldest buffer entry on any cycle with no higher-priority user; push and pop in one cycle SHALL leave count unchanged.
REQ-027 SHALL discard (pop without RAM write) buffer entries with address >= FB_DEPTH.
REQ-028 SHALL apply no read-after-write forwarding; a display read of an address still buffered returns the old RAM value.
REQ-029 SHALL implement states IDLE, DRAIN, CLEAR.
REQ-030 IDLE: clr_start=1 SHALL latch clr_color and go to DRAIN; clr_start in DRAIN/CLEAR SHALL be ignored.
REQ-031 DRAIN: SHALL continue draining buffer; when count==0 go to CLEAR with clear counter=0.
REQ-032 CLEAR: SHALL write latched colour to counter address on each granted slot, counter +1 per write; after write of FB_DEPTH-1 SHALL pulse clr_done for one cycle and return to IDLE.
REQ-033 clr_busy SHALL be 1 exactly in DRAIN and CLEAR.
REQ-034 mem_en SHALL be 0 in cycles with no granted slot; mem_we SHALL be 1 only for clear or drain writes.

Reset
REQ-035 rst low SHALL immediately force: state IDLE, buffer empty, clear counter 0, disp pipeline flushed, disp_pix=0, disp_pix_vld=0, clr_busy=0, clr_done=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-036 Reset asserted mid-clear or mid-drain SHALL abandon the operation without clr_done; buffered writes SHALL be lost.
REQ-037 host_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-038 Display only: disp_req every cycle, addr 0..7 preloaded 0..7 -> disp_pix_vld continuous from 3 cycles later, disp_pix 0..7 in order.
REQ-039 Host burst with display saturated: 5 host writes while disp_req held high -> first 4 accepted, host_ready 0 on 5th, no mem_we until disp_req drops, then 4 writes in FIFO order.
REQ-040 Out-of-range: host write addr 19200 data 7 -> accepted, no mem_we, buffer count returns to 0.
REQ-041 Clear: 2 buffered writes then clr_start, clr_color=3, no display -> buffer drains first, then 19200 writes of 3 to addr 0..19199, clr_done one pulse, clr_busy falls same cycle state returns IDLE.
REQ-042 Clear with display interleave: disp_req 50% duty during CLEAR -> display latency still 3, clear completes after exactly 19200 free slots.
REQ-043 Reset mid-clear at counter 100 -> all outputs to reset values asynchronously, no clr_done, host_ready 1 after release.
